mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM (1-cycle read latency, byte-strobed writes) between three requesters: instruction fetch, data read and data write. It grants at most one access per cycle and returns responses one cycle after the grant. Requests outside the RAM window complete without a RAM access. It sits between the Core buses and the RAM, replacing the separate read and write paths to the RAM array.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_arb_prio.sv | 22 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and RAM window helpers for the memory arbiter.
// Combinational only; no latency or flow control of its own.
package mem_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        DR   = 2'd2,
        DW   = 2'd3
    } req_id_t;

    localparam logic [31:0] DEF_RAM_BASE_ADDR  = 32'h0001_0000;
    localparam int          DEF_RAM_ADDR_WIDTH = 15;

    // Wide subtraction keeps addresses below the base from wrapping into the window.
    function automatic logic in_ram_window(input logic [31:0] addr,
                                           input logic [31:0] base = DEF_RAM_BASE_ADDR,
                                           input int          aw   = DEF_RAM_ADDR_WIDTH);
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (offset < (33'd1 << aw));
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed-priority grant (dw > dr > i) with a starvation override for fetch.
// Pure combinational, zero latency; losers simply stay ungranted.
module mem_arb_prio (
    input  logic [2:0] elig,    // {dw, dr, i}
    input  logic       starve,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        if (elig[0] && starve) begin
            gnt = 3'b001;
        end else if (elig[2]) begin
            gnt = 3'b100;
        end else if (elig[1]) begin
            gnt = 3'b010;
        end else if (elig[0]) begin
            gnt = 3'b001;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch, data read and data write; one grant per cycle.
// Responses one cycle after grant; requesters hold their request until their response pulse.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] RAM_BASE_ADDR  = DEF_RAM_BASE_ADDR,
    parameter int          RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter int          STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_avalid,
    input  logic [31:0]               i_addr,
    output logic [31:0]               i_data,
    output logic                      i_valid,
    input  logic                      dr_avalid,
    input  logic [31:0]               dr_addr,
    output logic [31:0]               dr_data,
    output logic                      dr_valid,
    input  logic                      dw_valid,
    input  logic [31:0]               dw_addr,
    input  logic [31:0]               dw_data,
    input  logic [3:0]                dw_strb,
    output logic                      dw_done,
    output logic                      ram_en,
    output logic [3:0]                ram_we,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    req_id_t         inflight_q, inflight_d;
    logic            inrange_q, inrange_d;
    logic [CW-1:0]   starve_cnt;
    logic            starve;
    logic [2:0]      elig, gnt;
    logic [31:0]     sel_addr, rsp_data, i_data_q, dr_data_q;

    // A requester is masked in its own response cycle while it still holds the request.
    assign elig[0] = !rst && i_avalid  && (inflight_q != I);
    assign elig[1] = !rst && dr_avalid && (inflight_q != DR);
    assign elig[2] = !rst && dw_valid  && (inflight_q != DW);
    assign starve  = (starve_cnt == CW'(STARVE_LIMIT));

    mem_arb_prio u_prio (
        .elig   (elig),
        .starve (starve),
        .gnt    (gnt)
    );

    always_comb begin
        inflight_d = NONE;
        sel_addr   = '0;
        unique case (gnt)
            3'b001: begin inflight_d = I;  sel_addr = i_addr;  end
            3'b010: begin inflight_d = DR; sel_addr = dr_addr; end
            3'b100: begin inflight_d = DW; sel_addr = dw_addr; end
            default: ;
        endcase
    end

    assign inrange_d = (inflight_d != NONE) && in_ram_window(sel_addr, RAM_BASE_ADDR, RAM_ADDR_WIDTH);
    assign ram_en    = inrange_d;
    assign ram_we    = (inrange_d && inflight_d == DW) ? dw_strb : 4'b0000;
    assign ram_wdata = dw_data;
    assign ram_addr  = (RAM_ADDR_WIDTH-2)'((sel_addr - RAM_BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= NONE;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inrange_q  <= 1'b0;
            starve_cnt <= '0;
            i_data_q   <= '0;
            dr_data_q  <= '0;
        end else begin
            inrange_q <= inrange_d;
            if (i_valid) begin
                i_data_q <= rsp_data;
            end
            if (dr_valid) begin
                dr_data_q <= rsp_data;
            end
            if (!i_avalid || gnt[0]) begin
                starve_cnt <= '0;
            end else if ((gnt[1] || gnt[2]) && elig[0] && !starve) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    // Gating with rst drops a response whose grant landed just before reset.
    assign rsp_data = inrange_q ? ram_rdata : 32'h0;
    assign i_valid  = !rst && (inflight_q == I);
    assign dr_valid = !rst && (inflight_q == DR);
    assign dw_done  = !rst && (inflight_q == DW);
    assign i_data   = i_valid  ? rsp_data : i_data_q;
    assign dr_data  = dr_valid ? rsp_data : dr_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural single-port RAM and a response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_avalid, dr_avalid, dw_valid;
    logic [31:0] i_addr, dr_addr, dw_addr, dw_data;
    logic [3:0]  dw_strb;
    logic [31:0] i_data, dr_data;
    logic        i_valid, dr_valid, dw_done;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [12:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ram     [0:8191];
    logic [31:0] ref_mem [0:8191];
    logic [31:0] i_q[$];
    logic [31:0] dr_q[$];
    int          dw_pending;

    logic        obs_i_valid, obs_dr_valid, obs_dw_done, obs_ram_en;
    logic [31:0] obs_i_data, obs_dr_data, obs_ram_wdata;
    logic [3:0]  obs_ram_we;
    logic [12:0] obs_ram_addr;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_avalid(i_avalid), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
        .dr_avalid(dr_avalid), .dr_addr(dr_addr), .dr_data(dr_data), .dr_valid(dr_valid),
        .dw_valid(dw_valid), .dw_addr(dw_addr), .dw_data(dw_data), .dw_strb(dw_strb),
        .dw_done(dw_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM: 1-cycle read latency, byte-strobed writes.
    initial begin
        for (int k = 0; k < 8192; k++) ram[k] = 32'h0;
        ram[0]    = 32'h0000_0013;
        ram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we == 4'b0000) begin
                    ram_rdata <= ram[ram_addr];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (ram_we[b]) ram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic cycle();
        @(negedge clk);
        obs_i_valid   = i_valid;   obs_i_data  = i_data;
        obs_dr_valid  = dr_valid;  obs_dr_data = dr_data;
        obs_dw_done   = dw_done;   obs_ram_en  = ram_en;
        obs_ram_we    = ram_we;    obs_ram_addr = ram_addr;
        obs_ram_wdata = ram_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        i_avalid = 1'b1; i_addr = 32'h0001_0000;
        for (int c = 0; c < 2; c++) begin
            cycle();
            tests_run++;
            if (obs_i_valid !== 1'b0 || obs_ram_en !== 1'b0 || obs_dr_valid !== 1'b0 || obs_dw_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_quiet: i_valid=%b ram_en=%b dr_valid=%b dw_done=%b, need all 0",
                         obs_i_valid, obs_ram_en, obs_dr_valid, obs_dw_done);
            end
            tests_run++;
            if (obs_i_data !== 32'h0 || obs_dr_data !== 32'h0 || obs_ram_we !== 4'h0) begin
                tests_failed++;
                $display("FAIL reset_values: i_data=%h dr_data=%h ram_we=%h, need 0",
                         obs_i_data, obs_dr_data, obs_ram_we);
            end
        end
        rst = 1'b0;
        i_q.push_back(ref_mem[0]);
        cycle();
        tests_run++;
        if (obs_ram_en !== 1'b1 || obs_i_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_grant: ram_en=%b i_valid=%b, need 1/0", obs_ram_en, obs_i_valid);
        end
        cycle();
        tests_run++;
        if (!obs_i_valid) begin
            tests_failed++;
            $display("FAIL reset_first_resp: i_valid=%b, need 1", obs_i_valid);
        end else begin
            exp = i_q.pop_front();
            if (obs_i_data !== exp) begin
                tests_failed++;
                $display("FAIL reset_first_data: got %h, need %h", obs_i_data, exp);
            end
        end
        i_avalid = 1'b0;
        i_q.delete();
        cycle();
    endtask

    task automatic test_single_fetch();
        logic [31:0] exp;
        i_avalid = 1'b1; i_addr = 32'h0001_0000;
        i_q.push_back(ref_mem[0]);
        for (int c = 0; c < 8 && i_q.size() > 0; c++) begin
            cycle();
            if (c == 0) begin
                tests_run++;
                if (obs_ram_en !== 1'b1 || obs_ram_addr !== 13'd0 || obs_ram_we !== 4'h0) begin
                    tests_failed++;
                    $display("FAIL fetch_grant: en=%b addr=%h we=%h, need 1/0/0", obs_ram_en, obs_ram_addr, obs_ram_we);
                end
            end
            if (obs_i_valid) begin
                exp = i_q.pop_front();
                tests_run++;
                if (obs_i_data !== exp || c != 1) begin
                    tests_failed++;
                    $display("FAIL fetch_resp: data=%h at cycle %0d, need %h at cycle 1", obs_i_data, c, exp);
                end
                i_avalid = 1'b0;
            end
        end
        tests_run++;
        if (i_q.size() != 0) begin
            tests_failed++;
            $display("FAIL fetch_timeout: %0d responses outstanding, need 0", i_q.size());
            i_q.delete();
        end
        i_avalid = 1'b0;
        cycle();
        tests_run++;
        if (obs_i_valid !== 1'b0 || obs_i_data !== 32'h0000_0013) begin
            tests_failed++;
            $display("FAIL fetch_hold: valid=%b data=%h, need 0/00000013", obs_i_valid, obs_i_data);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp;
        dw_valid = 1'b1; dw_addr = 32'h0001_0004; dw_data = 32'hA5A5_A5A5; dw_strb = 4'b0101;
        dr_avalid = 1'b1; dr_addr = 32'h0001_0004;
        ref_write(1, dw_data, dw_strb);
        dw_pending = 1;
        dr_q.push_back(ref_mem[1]);
        for (int c = 0; c < 8 && (dr_q.size() > 0 || dw_pending > 0); c++) begin
            cycle();
            if (c == 0) begin
                tests_run++;
                if (obs_ram_we !== 4'b0101 || obs_ram_addr !== 13'd1 || obs_ram_wdata !== 32'hA5A5_A5A5) begin
                    tests_failed++;
                    $display("FAIL contend_dw_first: we=%b addr=%h wdata=%h, need 0101/1/a5a5a5a5",
                             obs_ram_we, obs_ram_addr, obs_ram_wdata);
                end
            end
            if (c == 1) begin
                tests_run++;
                if (obs_ram_en !== 1'b1 || obs_ram_we !== 4'h0 || obs_ram_addr !== 13'd1) begin
                    tests_failed++;
                    $display("FAIL contend_dr_second: en=%b we=%h addr=%h, need 1/0/1", obs_ram_en, obs_ram_we, obs_ram_addr);
                end
            end
            if (obs_dw_done) begin
                tests_run++;
                if (dw_pending == 0 || c != 1) begin
                    tests_failed++;
                    $display("FAIL contend_dw_done: pulse at cycle %0d, pending %0d, need cycle 1", c, dw_pending);
                end
                if (dw_pending > 0) dw_pending--;
                dw_valid = 1'b0;
            end
            if (obs_dr_valid) begin
                exp = dr_q.pop_front();
                tests_run++;
                if (obs_dr_data !== exp || c != 2) begin
                    tests_failed++;
                    $display("FAIL contend_dr_data: %h at cycle %0d, need %h at cycle 2", obs_dr_data, c, exp);
                end
                dr_avalid = 1'b0;
            end
        end
        tests_run++;
        if (dr_q.size() != 0 || dw_pending != 0) begin
            tests_failed++;
            $display("FAIL contend_timeout: dr left %0d dw left %0d, need 0", dr_q.size(), dw_pending);
            dr_q.delete(); dw_pending = 0;
        end
        dw_valid = 1'b0; dr_avalid = 1'b0;
        cycle();
    endtask

    task automatic test_starvation();
        int exp_addr [11] = '{2, 1, 2, 1, 0, 2, 1, 2, 1, 2, 0};
        i_avalid = 1'b1;  i_addr  = 32'h0001_0000;
        dr_avalid = 1'b1; dr_addr = 32'h0001_0004;
        dw_valid = 1'b1;  dw_addr = 32'h0001_0008; dw_data = 32'h1234_5678; dw_strb = 4'hF;
        ref_write(2, dw_data, dw_strb);
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (c < 11) begin
                tests_run++;
                if (obs_ram_en !== 1'b1 || obs_ram_addr !== 13'(exp_addr[c])) begin
                    tests_failed++;
                    $display("FAIL starve_grant[%0d]: en=%b word=%0d, need word %0d", c, obs_ram_en, obs_ram_addr, exp_addr[c]);
                end
            end
            if (c > 0) begin
                tests_run++;
                if (obs_i_valid !== (exp_addr[c-1] == 0)) begin
                    tests_failed++;
                    $display("FAIL starve_ivalid[%0d]: got %b, need %b", c, obs_i_valid, exp_addr[c-1] == 0);
                end
            end
        end
        i_avalid = 1'b0; dr_avalid = 1'b0; dw_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] dw_a [2] = '{32'h0000_1000, 32'h0001_7FFC};
        logic        dw_e [2] = '{1'b0, 1'b1};
        logic [31:0] dr_a [4] = '{32'h0000_FFFC, 32'h0001_7FFC, 32'h0001_8000, 32'h0001_0004};
        logic        dr_e [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int          dr_w [4] = '{0, 8191, 0, 1};
        logic [31:0] exp;
        for (int k = 0; k < 2; k++) begin
            dw_valid = 1'b1; dw_addr = dw_a[k]; dw_data = 32'hCAFE_F00D; dw_strb = 4'hF;
            if (dw_e[k]) ref_write(8191, dw_data, dw_strb);
            cycle();
            tests_run++;
            if (obs_ram_en !== dw_e[k]) begin
                tests_failed++;
                $display("FAIL oor_dw_en[%0d]: ram_en=%b, need %b", k, obs_ram_en, dw_e[k]);
            end
            cycle();
            tests_run++;
            if (obs_dw_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL oor_dw_done[%0d]: dw_done=%b, need 1", k, obs_dw_done);
            end
            dw_valid = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            dr_avalid = 1'b1; dr_addr = dr_a[k];
            dr_q.push_back(dr_e[k] ? ref_mem[dr_w[k]] : 32'h0);
            cycle();
            tests_run++;
            if (obs_ram_en !== dr_e[k] || (dr_e[k] && obs_ram_addr !== 13'(dr_w[k]))) begin
                tests_failed++;
                $display("FAIL oor_dr_grant[%0d]: en=%b word=%0d, need %b/%0d", k, obs_ram_en, obs_ram_addr, dr_e[k], dr_w[k]);
            end
            cycle();
            exp = dr_q.pop_front();
            tests_run++;
            if (obs_dr_valid !== 1'b1 || obs_dr_data !== exp) begin
                tests_failed++;
                $display("FAIL oor_dr_resp[%0d]: valid=%b data=%h, need 1/%h", k, obs_dr_valid, obs_dr_data, exp);
            end
            dr_avalid = 1'b0;
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        dw_valid = 1'b1; dw_addr = 32'h0001_000C; dw_data = 32'hDEAD_BEEF; dw_strb = 4'hF;
        ref_write(3, dw_data, dw_strb);
        cycle();
        tests_run++;
        if (obs_ram_we !== 4'hF || obs_ram_addr !== 13'd3) begin
            tests_failed++;
            $display("FAIL b2b_write: we=%h addr=%h, need f/3", obs_ram_we, obs_ram_addr);
        end
        dr_avalid = 1'b1; dr_addr = 32'h0001_000C;
        dr_q.push_back(ref_mem[3]);
        cycle();
        tests_run++;
        if (obs_dw_done !== 1'b1 || obs_ram_en !== 1'b1 || obs_ram_we !== 4'h0 || obs_ram_addr !== 13'd3) begin
            tests_failed++;
            $display("FAIL b2b_overlap: done=%b en=%b we=%h addr=%h, need 1/1/0/3",
                     obs_dw_done, obs_ram_en, obs_ram_we, obs_ram_addr);
        end
        dw_valid = 1'b0;
        cycle();
        exp = dr_q.pop_front();
        tests_run++;
        if (obs_dr_valid !== 1'b1 || obs_dr_data !== exp) begin
            tests_failed++;
            $display("FAIL b2b_raw: valid=%b data=%h, need 1/%h", obs_dr_valid, obs_dr_data, exp);
        end
        dr_avalid = 1'b0;
        cycle();
    endtask

    task automatic test_midflight_reset();
        dr_avalid = 1'b1; dr_addr = 32'h0001_0004;
        cycle();
        tests_run++;
        if (obs_ram_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_grant: ram_en=%b, need 1", obs_ram_en);
        end
        rst = 1'b1; dr_avalid = 1'b0;
        cycle();
        tests_run++;
        if (obs_dr_valid !== 1'b0 || obs_ram_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_dropped: dr_valid=%b ram_en=%b, need 0/0", obs_dr_valid, obs_ram_en);
        end
        rst = 1'b0;
        cycle();
        tests_run++;
        if (obs_dr_valid !== 1'b0 || obs_dr_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_after: dr_valid=%b dr_data=%h, need 0/0", obs_dr_valid, obs_dr_data);
        end
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) ref_mem[k] = 32'h0;
        ref_mem[0] = 32'h0000_0013;
        rst = 1'b1;
        i_avalid = 1'b0; dr_avalid = 1'b0; dw_valid = 1'b0;
        i_addr = '0; dr_addr = '0; dw_addr = '0; dw_data = '0; dw_strb = '0;
        dw_pending = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_out_of_range();
        test_back_to_back();
        test_midflight_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
